det_job_scheduler: RTL and testbench

- Shares one serial Mealy pattern detector (1,0,1,x,0 non-overlapping, active-low async reset, registered output) among NREQ requesters.
- Each requester submits a WORD_W-bit word. The block arbitrates round-robin, clears the detector, and shifts the word in MSB first.
- It counts detector hits, then returns the hit count with a done pulse.
- Sits between client logic and the detector instance; the detector itself is unchanged.

---
 rtl/det_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/det_job_scheduler.sv | 168 ++++++++++++++++
 tb/tb_det_job_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/det_sched_pkg.sv
// Shared types and constants for the detector job scheduler.
package det_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } sched_state_e;

   // Detector pattern 1,0,1,x,0 is five bits long.
   localparam int PAT_LEN = 5;

   function automatic int cnt_width(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  id_o,
   output logic            vld_o
);

   logic [IDW:0] idx;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      vld_o = 1'b0;
      idx   = '0;
      for (int off = 0; off < NREQ; off++) begin
         // One extra bit holds ptr+off before the modulo wrap.
         idx = {1'b0, ptr_i} + (IDW+1)'(off);
         if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
         if (en_i && !vld_o && req_i[idx[IDW-1:0]]) begin
            vld_o                = 1'b1;
            id_o                 = idx[IDW-1:0];
            gnt_o[idx[IDW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/det_job_scheduler.sv
// Time-shares one serial 1,0,1,x,0 detector among NREQ requesters, returning hit counts.
// Optional EARLY_STOP_EN: finish a job on the first detector hit with hit_cnt=1.
module det_job_scheduler
   import det_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int WORD_W = 8,
   parameter int CNT_W  = cnt_width(WORD_W),
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WORD_W-1:0] req_data,
   output logic [NREQ-1:0]        gnt,
   output logic                   done,
   output logic [IDW-1:0]         done_id,
   output logic [CNT_W-1:0]       hit_cnt,
   output logic                   det_in,
   output logic                   det_rst_n,
   input  logic                   det_out
);

   localparam int            KW     = $clog2(WORD_W);
   localparam logic [KW-1:0] K_LAST = KW'(WORD_W - 1);

   sched_state_e      state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              done_q, done_d;
   logic [IDW-1:0]    done_id_q, done_id_d;
   logic [IDW-1:0]    win_q, win_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              det_in_q, det_in_d;
   logic              det_rst_n_q, det_rst_n_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [KW-1:0]     k_q, k_d;

   logic [WORD_W-1:0] word_sel;
   logic [NREQ-1:0]   arb_gnt;
   logic [IDW-1:0]    arb_id;
   logic              arb_vld;
   logic              hit_seen;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .en_i  (state_q == ST_IDLE),
      .gnt_o (arb_gnt),
      .id_o  (arb_id),
      .vld_o (arb_vld)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (win_q == IDW'(i)) word_sel = req_data[i*WORD_W +: WORD_W];
   end

   // det_out lags det_in by one cycle, so SHIFT k=0 still shows the cleared detector.
   assign hit_seen = det_out &&
                     ((state_q == ST_DRAIN) || (state_q == ST_SHIFT && k_q != '0));

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      hit_cnt_d   = hit_cnt_q;
      det_in_d    = 1'b0;
      det_rst_n_d = 1'b1;
      ptr_d       = ptr_q;
      win_d       = win_q;
      shreg_d     = shreg_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      if (hit_seen) cnt_d = sat_inc(cnt_q);

      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               gnt_d       = arb_gnt;
               win_d       = arb_id;
               ptr_d       = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
               det_rst_n_d = 1'b0;
               state_d     = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            shreg_d  = word_sel << 1;
            det_in_d = word_sel[WORD_W-1];
            cnt_d    = '0;
            k_d      = '0;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
`ifdef EARLY_STOP_EN
            if (hit_seen) begin
               gnt_d     = '0;
               done_d    = 1'b1;
               done_id_d = win_q;
               hit_cnt_d = CNT_W'(1);
               state_d   = ST_DONE;
            end else
`endif
            if (k_q == K_LAST) begin
               state_d = ST_DRAIN;
            end else begin
               det_in_d = shreg_q[WORD_W-1];
               shreg_d  = shreg_q << 1;
               k_d      = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            gnt_d     = '0;
            done_d    = 1'b1;
            done_id_d = win_q;
            hit_cnt_d = cnt_d;
            state_d   = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         hit_cnt_q   <= '0;
         det_in_q    <= 1'b0;
         det_rst_n_q <= 1'b0;
         ptr_q       <= '0;
         win_q       <= '0;
         shreg_q     <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         hit_cnt_q   <= hit_cnt_d;
         det_in_q    <= det_in_d;
         det_rst_n_q <= det_rst_n_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         shreg_q     <= shreg_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign hit_cnt   = hit_cnt_q;
   assign det_in    = det_in_q;
   assign det_rst_n = det_rst_n_q;

endmodule

// File: tb/tb_det_job_scheduler.sv
// Bench for det_job_scheduler: two instances (4x8-bit, 2x10-bit) each driving a behavioural detector.
module tb_det_job_scheduler;
   import det_sched_pkg::*;

   localparam int N_A = 4, W_A = 8, N_B = 2, W_B = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N_A-1:0]     req_a, gnt_a;
   logic [N_A*W_A-1:0] data_a;
   logic               done_a, det_in_a, det_rst_n_a, det_out_a;
   logic [1:0]         id_a;
   logic [3:0]         cnt_a;

   logic [N_B-1:0]     req_b, gnt_b;
   logic [N_B*W_B-1:0] data_b;
   logic               done_b, det_in_b, det_rst_n_b, det_out_b;
   logic [0:0]         id_b;
   logic [3:0]         cnt_b;

   det_job_scheduler #(.NREQ(N_A), .WORD_W(W_A)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .req_data(data_a), .gnt(gnt_a),
      .done(done_a), .done_id(id_a), .hit_cnt(cnt_a), .det_in(det_in_a),
      .det_rst_n(det_rst_n_a), .det_out(det_out_a));

   det_job_scheduler #(.NREQ(N_B), .WORD_W(W_B)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .req_data(data_b), .gnt(gnt_b),
      .done(done_b), .done_id(id_b), .hit_cnt(cnt_b), .det_in(det_in_b),
      .det_rst_n(det_rst_n_b), .det_out(det_out_b));

   // Detector: non-overlapping 1,0,1,x,0, hit registered, history cleared on hit.
   function automatic logic [8:0] det_step(input logic [4:0] hist, input logic [2:0] n,
                                           input logic b);
      logic [4:0] h;
      h = {hist[3:0], b};
      if (n >= 3'(PAT_LEN - 1) && h[4] && !h[3] && h[2] && !h[0])
         return {1'b1, 3'd0, 5'd0};
      return {1'b0, (n >= 3'(PAT_LEN - 1)) ? n : n + 3'd1, h};
   endfunction

   logic [4:0] ha, hb;
   logic [2:0] na, nb;

   always @(posedge clk or negedge det_rst_n_a)
      if (!det_rst_n_a) begin ha <= '0; na <= '0; det_out_a <= 1'b0; end
      else {det_out_a, na, ha} <= det_step(ha, na, det_in_a);

   always @(posedge clk or negedge det_rst_n_b)
      if (!det_rst_n_b) begin hb <= '0; nb <= '0; det_out_b <= 1'b0; end
      else {det_out_b, nb, hb} <= det_step(hb, nb, det_in_b);

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [1:0]  id;
      int          cnt;
      int          lat_es;
   } vec_t;

   vec_t tab[10];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Waits for the grant; exp_gap is negedges from call to first gnt.
   task automatic start_a(input string nm, input logic [3:0] exp_gnt, input int exp_gap);
      int c, spur;
      c = 0; spur = 0;
      do begin
         @(negedge clk);
         c++;
         if (done_a) spur++;
      end while (gnt_a == '0 && c < 40);
      chk({nm, " gap"}, c, exp_gap);
      chk({nm, " gnt"}, int'(gnt_a), int'(exp_gnt));
      chk({nm, " stray done"}, spur, 0);
   endtask

   // Waits for done; lat0 is negedges already elapsed since gnt rose.
   task automatic finish_a(input string nm, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                           input int exp_cnt, input int exp_lat, input int lat0);
      int lat, bad;
      lat = lat0; bad = 0;
      while (!done_a && lat < 60) begin
         @(negedge clk);
         lat++;
         if (!done_a && gnt_a != exp_gnt) bad++;
      end
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " gnt held"}, bad, 0);
      chk({nm, " done_id"}, int'(id_a), int'(exp_id));
      chk({nm, " hit_cnt"}, int'(cnt_a), exp_cnt);
      chk({nm, " gnt at done"}, int'(gnt_a), 0);
   endtask

   function automatic int ecnt(input int c);
`ifdef EARLY_STOP_EN
      return (c != 0) ? 1 : 0;
`else
      return c;
`endif
   endfunction

   initial begin
      logic [3:0] oh;
      int         lat_exp, c;

      tab[0] = '{4'b0001, 32'h0000_00A0, 2'd0, 1, 7};
      tab[1] = '{4'b0001, 32'h0000_00B0, 2'd0, 1, 7};
      tab[2] = '{4'b0001, 32'h0000_00FF, 2'd0, 0, 10};
      tab[3] = '{4'b0001, 32'h0000_0000, 2'd0, 0, 10};
      tab[4] = '{4'b1000, 32'h2DFF_14A0, 2'd3, 1, 9};
      tab[5] = '{4'b1111, 32'h2DFF_14A0, 2'd0, 1, 7};
      tab[6] = '{4'b1111, 32'h2DFF_14A0, 2'd1, 1, 10};
      tab[7] = '{4'b1111, 32'h2DFF_14A0, 2'd2, 0, 10};
      tab[8] = '{4'b1111, 32'h2DFF_14A0, 2'd3, 1, 9};
      tab[9] = '{4'b1111, 32'h2DFF_14A0, 2'd0, 1, 7};

      rst = 1'b1; req_a = '0; data_a = '0; req_b = '0; data_b = '0;
      repeat (3) @(negedge clk);
      chk("rst gnt_a", int'(gnt_a), 0);
      chk("rst done_a", int'(done_a), 0);
      chk("rst done_id_a", int'(id_a), 0);
      chk("rst hit_cnt_a", int'(cnt_a), 0);
      chk("rst det_in_a", int'(det_in_a), 0);
      chk("rst det_rst_n_a", int'(det_rst_n_a), 0);
      chk("rst gnt_b", int'(gnt_b), 0);
      chk("rst det_rst_n_b", int'(det_rst_n_b), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle det_rst_n_a", int'(det_rst_n_a), 1);
      chk("idle gnt_a", int'(gnt_a), 0);

      for (int i = 0; i < 10; i++) begin
         req_a  = tab[i].req;
         data_a = tab[i].data;
         oh     = 4'b0001 << tab[i].id;
`ifdef EARLY_STOP_EN
         lat_exp = tab[i].lat_es;
`else
         lat_exp = W_A + 2;
`endif
         start_a($sformatf("vec%0d", i), oh, (i == 0) ? 1 : 2);
         finish_a($sformatf("vec%0d", i), oh, tab[i].id, ecnt(tab[i].cnt), lat_exp, 0);
      end

      // Reset during SHIFT k=3, then the held request restarts from scratch.
      req_a = 4'b0001; data_a = 32'h0000_00A0;
      start_a("rstjob", 4'b0001, 2);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst gnt", int'(gnt_a), 0);
      chk("midrst det_rst_n", int'(det_rst_n_a), 0);
      chk("midrst done", int'(done_a), 0);
      rst = 1'b0;
`ifdef EARLY_STOP_EN
      lat_exp = 7;
`else
      lat_exp = W_A + 2;
`endif
      start_a("restart", 4'b0001, 1);
      finish_a("restart", 4'b0001, 2'd0, 1, lat_exp, 0);

      // Word changes and req drops mid-job; result follows the latched word.
      req_a = 4'b0010; data_a = 32'h0000_A000;
      start_a("drop", 4'b0010, 2);
      repeat (3) @(negedge clk);
      req_a = '0; data_a = '1;
      finish_a("drop", 4'b0010, 2'd1, 1, lat_exp, 3);
      @(negedge clk);
      chk("drop idle gnt", int'(gnt_a), 0);

      // 10-bit word with two hits.
      req_b = 2'b01; data_b = {10'd0, 10'b10100_10100};
      c = 0;
      do begin @(negedge clk); c++; end while (gnt_b == '0 && c < 40);
      chk("w10 gap", c, 1);
      chk("w10 gnt", int'(gnt_b), 1);
      c = 0;
      while (!done_b && c < 60) begin @(negedge clk); c++; end
`ifdef EARLY_STOP_EN
      chk("w10 latency", c, 7);
`else
      chk("w10 latency", c, W_B + 2);
`endif
      chk("w10 done_id", int'(id_b), 0);
      chk("w10 hit_cnt", int'(cnt_b), ecnt(2) == 1 ? 1 : 2);
      req_b = '0;
      @(negedge clk);
      chk("w10 done pulse", int'(done_b), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
